// File: rtl/boot_sequencer_if.sv
// Boot sequencer connection bundle: start/config, loader handshake and per-core
// fetch/done/pass channels. master = sequencer side, slave = platform side.
interface boot_sequencer_if #(
  parameter int NUM_CORES = 1,
  parameter int TIMEOUT_W = 32
);
  logic                 start_i;
  logic [1:0]           mode_i;
  logic [NUM_CORES-1:0] core_en_i;
  logic [TIMEOUT_W-1:0] timeout_cycles_i;
  logic                 load_req_o;
  logic                 load_done_i;
  logic                 soc_rst_n_o;
  logic [NUM_CORES-1:0] fetch_enable_o;
  logic [NUM_CORES-1:0] done_i;
  logic [NUM_CORES-1:0] pass_i;
  logic                 busy_o;
  logic                 finished_o;
  logic [1:0]           exit_status_o;

  modport master (
    input  start_i, mode_i, core_en_i, timeout_cycles_i, load_done_i, done_i, pass_i,
    output load_req_o, soc_rst_n_o, fetch_enable_o, busy_o, finished_o, exit_status_o
  );

  modport slave (
    output start_i, mode_i, core_en_i, timeout_cycles_i, load_done_i, done_i, pass_i,
    input  load_req_o, soc_rst_n_o, fetch_enable_o, busy_o, finished_o, exit_status_o
  );
endinterface

// File: rtl/boot_sequencer.sv
// Cycle-exact SoC boot sequencer: reset hold, settle, optional external load,
// fetch enable, per-core completion capture with run watchdog, sticky exit status.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | SoC held in reset, waiting for start
// RESET      | SoC reset asserted for RST_CYCLES
// SETTLE     | reset released, waiting SETTLE_CYCLES
// LOAD       | external loader requested, waiting for load_done_i
// FETCH_WAIT | FETCH_DELAY cycles before fetch enable
// RUN        | cores fetching; collecting done/pass, watchdog active
// DONE       | exit status valid and held; start restarts the sequence
module boot_sequencer #(
  parameter int NUM_CORES     = 1,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int FETCH_DELAY   = 8,
  parameter int TIMEOUT_W     = 32
) (
  input logic              clk,
  input logic              rst,
  boot_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_RESET      = 3'd1;
  localparam logic [2:0] S_SETTLE     = 3'd2;
  localparam logic [2:0] S_LOAD       = 3'd3;
  localparam logic [2:0] S_FETCH_WAIT = 3'd4;
  localparam logic [2:0] S_RUN        = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam logic [1:0] ST_PASS  = 2'b00;
  localparam logic [1:0] ST_FAIL  = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b10;

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > FETCH_DELAY) ? MAX_A : FETCH_DELAY;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LD  = CNT_W'(FETCH_DELAY - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     tmr_q, tmr_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 wd_en_q, wd_en_d;
  logic [1:0]           mode_q, mode_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] done_q, done_d;
  logic [NUM_CORES-1:0] pass_q, pass_d;
  logic [NUM_CORES-1:0] hit;
  logic                 err_entry;

  logic                 load_req_q, load_req_d;
  logic                 soc_rst_n_q, soc_rst_n_d;
  logic [NUM_CORES-1:0] fetch_en_q, fetch_en_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;
  logic [1:0]           status_q, status_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    wd_d      = wd_q;
    wd_en_d   = wd_en_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    done_d    = done_q;
    pass_d    = pass_q;
    status_d  = status_q;
    hit       = '0;
    err_entry = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          mode_d  = bus.mode_i;
          mask_d  = bus.core_en_i;
          wd_d    = bus.timeout_cycles_i;
          wd_en_d = |bus.timeout_cycles_i;
          done_d  = '0;
          pass_d  = '0;
          if ((bus.mode_i == 2'd3) || (bus.core_en_i == '0)) begin
            state_d   = S_DONE;
            status_d  = ST_ERROR;
            err_entry = 1'b1;
          end else begin
            state_d = S_RESET;
            tmr_d   = RST_LD;
          end
        end
      end
      S_RESET: begin
        if (tmr_q == '0) begin
          state_d = S_SETTLE;
          tmr_d   = SETTLE_LD;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (tmr_q == '0) begin
          state_d = (mode_q != 2'd0) ? S_LOAD : S_FETCH_WAIT;
          tmr_d   = FETCH_LD;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (bus.load_done_i) begin
          state_d = S_FETCH_WAIT;
          tmr_d   = FETCH_LD;
        end
      end
      S_FETCH_WAIT: begin
        if (tmr_q == '0) begin
          state_d = S_RUN;
        end else begin
          tmr_d = tmr_q - CNT_W'(1);
        end
      end
      S_RUN: begin
        // First done per enabled core wins; later done/pass activity is ignored.
        hit    = bus.done_i & mask_q & ~done_q;
        done_d = done_q | hit;
        pass_d = (pass_q & ~hit) | (bus.pass_i & hit);
        if (done_d == mask_q) begin
          state_d  = S_DONE;
          status_d = ((pass_d & mask_q) == mask_q) ? ST_PASS : ST_FAIL;
        end else if (wd_en_q && (wd_q == TIMEOUT_W'(1))) begin
          state_d  = S_DONE;
          status_d = ST_ERROR;
        end else if (wd_q != '0) begin
          wd_d = wd_q - TIMEOUT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    load_req_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    finished_d  = (state_d == S_DONE);
    soc_rst_n_d = soc_rst_n_q;
    fetch_en_d  = fetch_en_q;
    case (state_d)
      S_IDLE, S_RESET: begin
        soc_rst_n_d = 1'b0;
        fetch_en_d  = '0;
      end
      S_RUN: begin
        soc_rst_n_d = 1'b1;
        fetch_en_d  = mask_d;
      end
      S_DONE: begin
        if (err_entry) begin
          soc_rst_n_d = 1'b0;
          fetch_en_d  = '0;
        end
      end
      default: begin
        soc_rst_n_d = 1'b1;
        fetch_en_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      wd_q        <= '0;
      wd_en_q     <= 1'b0;
      mode_q      <= 2'd0;
      mask_q      <= '0;
      done_q      <= '0;
      pass_q      <= '0;
      load_req_q  <= 1'b0;
      soc_rst_n_q <= 1'b0;
      fetch_en_q  <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      status_q    <= ST_ERROR;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      wd_q        <= wd_d;
      wd_en_q     <= wd_en_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      load_req_q  <= load_req_d;
      soc_rst_n_q <= soc_rst_n_d;
      fetch_en_q  <= fetch_en_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      status_q    <= status_d;
    end
  end

  assign bus.load_req_o     = load_req_q;
  assign bus.soc_rst_n_o    = soc_rst_n_q;
  assign bus.fetch_enable_o = fetch_en_q;
  assign bus.busy_o         = busy_q;
  assign bus.finished_o     = finished_q;
  assign bus.exit_status_o  = status_q;

endmodule
